execute: RTL and testbench

Per-core execute/retire stage directly downstream of `select`. Consumes the decoded instruction, its cell pointer and the cell value `select` produced, and computes the result:
- PLUS/MINUS modify the cell.
- RIGHT/LEFT move the pointer.
- BRZ resolves a branch.
- HALT stops the core.

Modified cells go through a small writeback buffer to the shared register-file arbiter, which writes the value back and releases the lock `select` placed on the entry.

---
 rtl/tb_pkg.sv | 19 +
 rtl/execute_wb_fifo.sv | 71 +++++++
 rtl/execute.sv | 110 +++++++++++
 tb/tb_execute.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_pkg.sv
// Shared definitions for the execute stage: opcodes, writeback entry, core state.
package tb_pkg;

    localparam logic [3:0] NOP   = 4'h0;
    localparam logic [3:0] PLUS  = 4'h1;
    localparam logic [3:0] MINUS = 4'h2;
    localparam logic [3:0] RIGHT = 4'h3;
    localparam logic [3:0] LEFT  = 4'h4;
    localparam logic [3:0] BRZ   = 4'h5;
    localparam logic [3:0] HALT  = 4'hF;

    typedef struct packed {
        logic [15:0] tag;
        logic [15:0] val;
    } wb_entry_t;

    typedef enum logic [0:0] {RUN, HALTED} state_t;

endpackage

// File: rtl/execute_wb_fifo.sv
// Writeback FIFO with a combinational youngest-match lookup used for operand forwarding.
module wb_fifo
    import tb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [15:0]              lookup_tag,
    output logic                     lookup_hit,
    output logic [15:0]              lookup_val
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;
    logic [AW-1:0]     idx;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Head is zeroed when empty so reset leaves wb_tag/wb_val at zero.
    always_comb begin
        head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_val = '0;
        idx        = rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q && mem_q[idx].tag == lookup_tag) begin
                lookup_hit = 1'b1;
                lookup_val = mem_q[idx].val;
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/execute.sv
// Execute/retire stage: applies cell ops via a forwarding writeback buffer,
// moves the pointer, resolves branches and halts the core.
module execute
    import tb_pkg::*;
#(
    parameter int unsigned NCORES   = 4,
    parameter int unsigned CORE_ID  = 0,
    parameter int unsigned WB_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [15:0]                 ins,
    input  logic [15:0]                 ptr,
    input  logic [15:0]                 val,
    input  logic                        stall,
    output logic                        in_ready,
    output logic                        wb_req,
    output logic [$clog2(NCORES)-1:0]   wb_core,
    output logic [15:0]                 wb_tag,
    output logic [15:0]                 wb_val,
    input  logic                        wb_gnt,
    output logic                        redirect_valid,
    output logic [11:0]                 redirect_pc,
    output logic [15:0]                 ptr_out,
    output logic                        retire,
    output logic                        halted
);

    localparam int unsigned CIDW = $clog2(NCORES);
    localparam int unsigned CNTW = $clog2(WB_DEPTH) + 1;

    state_t          state_q, state_d;
    logic [15:0]     ptr_out_q;
    logic            retire_q;
    logic            redirect_valid_q;
    logic [11:0]     redirect_pc_q;

    logic [3:0]      opcode;
    logic            accept;
    logic            push;
    logic            pop;
    wb_entry_t       push_data;
    wb_entry_t       head;
    logic [CNTW-1:0] count;
    logic            fwd_hit;
    logic [15:0]     fwd_val;
    logic [15:0]     eval;

    wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .lookup_tag (ptr),
        .lookup_hit (fwd_hit),
        .lookup_val (fwd_val)
    );

    // Accept/forward/push decode; ready deliberately ignores same-cycle pops.
    always_comb begin
        opcode    = ins[15:12];
        in_ready  = !rst && (state_q == RUN) && (count < CNTW'(WB_DEPTH));
        accept    = in_valid && !stall && in_ready;
        eval      = fwd_hit ? fwd_val : val;
        push      = accept && (opcode == PLUS || opcode == MINUS);
        push_data = '{tag: ptr, val: (opcode == PLUS) ? eval + 16'd1 : eval - 16'd1};
        pop       = (count != '0) && wb_gnt;
    end

    // Next-state: HALTED is sticky until reset.
    always_comb begin
        state_d = state_q;
        if (accept && opcode == HALT) state_d = HALTED;
    end

    // Architectural registers and one-cycle retire/redirect pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            ptr_out_q        <= '0;
            retire_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            retire_q         <= accept;
            redirect_valid_q <= accept && (opcode == BRZ) && (eval == 16'd0);
            if (accept && opcode == BRZ && eval == 16'd0) redirect_pc_q <= ins[11:0];
            if (accept && opcode == RIGHT) ptr_out_q <= ptr_out_q + 16'd1;
            if (accept && opcode == LEFT)  ptr_out_q <= ptr_out_q - 16'd1;
        end
    end

    assign wb_req         = (count != '0);
    assign wb_core        = CIDW'(CORE_ID);
    assign wb_tag         = head.tag;
    assign wb_val         = head.val;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign ptr_out        = ptr_out_q;
    assign retire         = retire_q;
    assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_execute;
    import tb_pkg::*;

    localparam int unsigned WB_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] ins, ptr, val;
    logic        stall;
    logic        in_ready;
    logic        wb_req;
    logic [1:0]  wb_core;
    logic [15:0] wb_tag, wb_val;
    logic        wb_gnt;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [15:0] ptr_out;
    logic        retire;
    logic        halted;

    execute #(
        .NCORES   (4),
        .CORE_ID  (0),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .ins            (ins),
        .ptr            (ptr),
        .val            (val),
        .stall          (stall),
        .in_ready       (in_ready),
        .wb_req         (wb_req),
        .wb_core        (wb_core),
        .wb_tag         (wb_tag),
        .wb_val         (wb_val),
        .wb_gnt         (wb_gnt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ptr_out        (ptr_out),
        .retire         (retire),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: pending writebacks in program order.
    logic [31:0] pend[$];
    logic [31:0] dut_log[$];
    logic [15:0] m_ptr;
    logic        m_halted;
    logic        m_retire;
    logic        m_redir;
    logic [11:0] m_redir_pc;

    // Pre-edge expectations and observations of the last step.
    logic        exp_ready, exp_req;
    logic [31:0] exp_head;
    logic        obs_ready, obs_req;
    logic [15:0] obs_tag, obs_val;

    function automatic logic [15:0] mk(input logic [3:0] op);
        return {op, 12'h000};
    endfunction

    task automatic model_clear();
        pend.delete();
        dut_log.delete();
        m_ptr      = 16'h0;
        m_halted   = 1'b0;
        m_retire   = 1'b0;
        m_redir    = 1'b0;
        m_redir_pc = 12'h0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        ins      = 16'h0;
        ptr      = 16'h0;
        val      = 16'h0;
        stall    = 1'b0;
        wb_gnt   = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, advance the model, return just after the edge.
    task automatic step(input logic v, input logic [15:0] i_ins, input logic [15:0] p,
                        input logic [15:0] vv, input logic st, input logic g);
        logic        acc;
        logic [15:0] ev;
        logic [3:0]  op;
        in_valid = v;
        ins      = i_ins;
        ptr      = p;
        val      = vv;
        stall    = st;
        wb_gnt   = g;
        #1;
        obs_ready = in_ready;
        obs_req   = wb_req;
        obs_tag   = wb_tag;
        obs_val   = wb_val;
        exp_ready = !m_halted && (pend.size() < WB_DEPTH);
        exp_req   = (pend.size() != 0);
        exp_head  = exp_req ? pend[0] : 32'h0;
        if (obs_req && g) dut_log.push_back({obs_tag, obs_val});
        acc = v && !st && exp_ready;
        ev  = vv;
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k][31:16] == p) begin
                ev = pend[k][15:0];
                break;
            end
        end
        op       = i_ins[15:12];
        m_retire = acc;
        m_redir  = 1'b0;
        if (exp_req && g) void'(pend.pop_front());
        if (acc) begin
            case (op)
                PLUS:  pend.push_back({p, ev + 16'd1});
                MINUS: pend.push_back({p, ev - 16'd1});
                RIGHT: m_ptr = m_ptr + 16'd1;
                LEFT:  m_ptr = m_ptr - 16'd1;
                BRZ: if (ev == 16'd0) begin
                    m_redir    = 1'b1;
                    m_redir_pc = i_ins[11:0];
                end
                HALT:  m_halted = 1'b1;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && pend.size() != 0; k++) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        wb_gnt   = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_cmp++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL reset_wb_req got %b want 0", wb_req); end
        n_cmp++; if ({wb_tag, wb_val} !== 32'h0) begin n_fail++; $display("FAIL reset_wb_head got %h want 0", {wb_tag, wb_val}); end
        n_cmp++; if ({redirect_valid, redirect_pc} !== 13'h0) begin n_fail++; $display("FAIL reset_redirect got %b/%h want 0/000", redirect_valid, redirect_pc); end
        n_cmp++; if (ptr_out !== 16'h0) begin n_fail++; $display("FAIL reset_ptr_out got %h want 0000", ptr_out); end
        n_cmp++; if ({retire, halted} !== 2'b00) begin n_fail++; $display("FAIL reset_retire_halted got %b want 00", {retire, halted}); end
        n_cmp++; if (wb_core !== 2'd0) begin n_fail++; $display("FAIL wb_core got %0d want 0", wb_core); end
        model_clear();
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL after_reset_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_plus_basic();
        step(1'b1, mk(PLUS), 16'h0010, 16'h00FF, 1'b0, 1'b1);
        in_valid = 1'b0;
        n_cmp++; if (wb_req !== 1'b1) begin n_fail++; $display("FAIL plus_wb_req got %b want 1", wb_req); end
        n_cmp++; if ({wb_tag, wb_val} !== 32'h0010_0100) begin n_fail++; $display("FAIL plus_head got %h want 00100100", {wb_tag, wb_val}); end
        n_cmp++; if (retire !== 1'b1) begin n_fail++; $display("FAIL plus_retire got %b want 1", retire); end
        drain();
        n_cmp++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL plus_drained got %b want 0", wb_req); end
    endtask

    task automatic test_wrap();
        dut_log.delete();
        step(1'b1, mk(MINUS), 16'h0020, 16'h0000, 1'b0, 1'b1);
        step(1'b1, mk(PLUS),  16'h0021, 16'hFFFF, 1'b0, 1'b1);
        drain();
        n_cmp++;
        if (dut_log.size() != 2 || dut_log[0] !== 32'h0020_FFFF || dut_log[1] !== 32'h0021_0000) begin
            n_fail++;
            $display("FAIL wrap_writebacks got %0d entries first %h want 0020ffff,00210000",
                     dut_log.size(), dut_log.size() > 0 ? dut_log[0] : 32'h0);
        end
    endtask

    task automatic test_full_backpressure();
        dut_log.delete();
        step(1'b1, mk(PLUS), 16'h00A0, 16'd5, 1'b0, 1'b0);
        step(1'b1, mk(PLUS), 16'h00B0, 16'd5, 1'b0, 1'b0);
        step(1'b1, mk(PLUS), 16'h00C0, 16'd5, 1'b0, 1'b0);
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_not_ready got %b want 0", obs_ready); end
        step(1'b1, mk(PLUS), 16'h00C0, 16'd5, 1'b0, 1'b1);
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_not_ready got %b want 0", obs_ready); end
        n_cmp++; if (obs_tag !== 16'h00A0) begin n_fail++; $display("FAIL full_head_a got %h want 00a0", obs_tag); end
        step(1'b1, mk(PLUS), 16'h00C0, 16'd5, 1'b0, 1'b1);
        n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b want 1", obs_ready); end
        n_cmp++; if (retire !== 1'b1) begin n_fail++; $display("FAIL full_c_retire got %b want 1", retire); end
        drain();
        n_cmp++;
        if (dut_log.size() != 3 || dut_log[0] !== 32'h00A0_0006 || dut_log[1] !== 32'h00B0_0006
            || dut_log[2] !== 32'h00C0_0006) begin
            n_fail++;
            $display("FAIL full_order got %0d entries want a0=6,b0=6,c0=6", dut_log.size());
        end
    endtask

    task automatic test_forwarding();
        dut_log.delete();
        step(1'b1, mk(PLUS), 16'h0055, 16'd3, 1'b0, 1'b0);
        step(1'b1, mk(PLUS), 16'h0055, 16'd3, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (dut_log.size() != 2 || dut_log[0] !== 32'h0055_0004 || dut_log[1] !== 32'h0055_0005) begin
            n_fail++;
            $display("FAIL fwd_writebacks got %0d entries last %h want 00550004,00550005",
                     dut_log.size(), dut_log.size() > 0 ? dut_log[dut_log.size()-1] : 32'h0);
        end
    endtask

    task automatic test_branch();
        step(1'b1, 16'h5123, 16'h0001, 16'h0000, 1'b0, 1'b1);
        n_cmp++; if ({redirect_valid, redirect_pc} !== {1'b1, 12'h123}) begin n_fail++; $display("FAIL brz_taken got %b/%h want 1/123", redirect_valid, redirect_pc); end
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        n_cmp++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL brz_one_cycle got %b want 0", redirect_valid); end
        step(1'b1, 16'h5123, 16'h0001, 16'h0001, 1'b0, 1'b1);
        n_cmp++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL brz_not_taken got %b want 0", redirect_valid); end
        n_cmp++; if (retire !== 1'b1) begin n_fail++; $display("FAIL brz_retire got %b want 1", retire); end
    endtask

    task automatic test_left_halt();
        do_reset();
        dut_log.delete();
        step(1'b1, mk(LEFT), 16'h0, 16'h0, 1'b0, 1'b0);
        n_cmp++; if (ptr_out !== 16'hFFFF) begin n_fail++; $display("FAIL left_wrap got %h want ffff", ptr_out); end
        step(1'b1, mk(PLUS), 16'h0077, 16'd7, 1'b0, 1'b0);
        step(1'b1, mk(HALT), 16'h0, 16'h0, 1'b0, 1'b0);
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted got %b want 1", halted); end
        step(1'b1, mk(RIGHT), 16'h0, 16'h0, 1'b0, 1'b0);
        n_cmp++; if ({obs_ready, obs_req} !== 2'b01) begin n_fail++; $display("FAIL halt_ready_req got %b want 01", {obs_ready, obs_req}); end
        n_cmp++; if ({retire, ptr_out} !== {1'b0, 16'hFFFF}) begin n_fail++; $display("FAIL halt_no_exec got %b/%h want 0/ffff", retire, ptr_out); end
        drain();
        n_cmp++;
        if (dut_log.size() != 1 || dut_log[0] !== 32'h0077_0008) begin
            n_fail++;
            $display("FAIL halt_drain got %0d entries want 00770008", dut_log.size());
        end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got %b want 1", halted); end
        test_reset();
    endtask

    task automatic test_random();
        logic [3:0]  ops [7];
        logic [3:0]  op;
        logic [15:0] p;
        ops[0] = NOP; ops[1] = PLUS; ops[2] = MINUS; ops[3] = RIGHT;
        ops[4] = LEFT; ops[5] = BRZ; ops[6] = 4'h9;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            op = ops[$urandom_range(0, 6)];
            p  = 16'h0040 + 16'($urandom_range(0, 2));
            step($urandom_range(0, 3) != 0, {op, 12'($urandom)}, p,
                 ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
            n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_in_ready c=%0d got %b want %b", c, obs_ready, exp_ready); end
            n_cmp++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL rand_wb_req c=%0d got %b want %b", c, obs_req, exp_req); end
            if (exp_req) begin
                n_cmp++; if ({obs_tag, obs_val} !== exp_head) begin n_fail++; $display("FAIL rand_head c=%0d got %h want %h", c, {obs_tag, obs_val}, exp_head); end
            end
            n_cmp++; if (retire !== m_retire) begin n_fail++; $display("FAIL rand_retire c=%0d got %b want %b", c, retire, m_retire); end
            n_cmp++; if (redirect_valid !== m_redir) begin n_fail++; $display("FAIL rand_redirect c=%0d got %b want %b", c, redirect_valid, m_redir); end
            if (m_redir) begin
                n_cmp++; if (redirect_pc !== m_redir_pc) begin n_fail++; $display("FAIL rand_redirect_pc c=%0d got %h want %h", c, redirect_pc, m_redir_pc); end
            end
            n_cmp++; if (ptr_out !== m_ptr) begin n_fail++; $display("FAIL rand_ptr_out c=%0d got %h want %h", c, ptr_out, m_ptr); end
        end
        drain();
        n_cmp++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL rand_drained got %b want 0", wb_req); end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        ins      = 16'h0;
        ptr      = 16'h0;
        val      = 16'h0;
        stall    = 1'b0;
        wb_gnt   = 1'b0;
        model_clear();
        #1;
        test_reset();
        test_plus_basic();
        test_wrap();
        test_full_backpressure();
        test_forwarding();
        test_branch();
        test_left_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
